// File: rtl/alu_instr_controller_if.sv
// Control bundle between the ALU instruction sequencer and the datapath.
// The master side is the sequencer. The slave side is the datapath, or a bench standing in for it.
interface alu_instr_controller_if;
    logic        run;
    logic [31:0] ir;
    logic        mem_ready;
    logic        PCout;
    logic        MARin;
    logic        incPC;
    logic        Zin;
    logic        ZLowOut;
    logic        ZHighOut;
    logic        PCin;
    logic        Read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        HIin;
    logic        LOin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [4:0]  opcode;
    logic        busy;
    logic        done;
    logic        fault;

    modport master (
        input  run, ir, mem_ready,
        output PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, Read, MDRin,
               MDRout, IRin, Yin, HIin, LOin, Rin, Rout, opcode, busy, done, fault
    );

    modport slave (
        output run, ir, mem_ready,
        input  PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, Read, MDRin,
               MDRout, IRin, Yin, HIin, LOin, Rin, Rout, opcode, busy, done, fault
    );
endinterface

// File: rtl/alu_instr_controller.sv
// Sequencer FSM that issues fetch, operand-staging and write-back strobes
// for one register-format ALU instruction per run pulse.
module alu_instr_controller #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                          clk,
    input  logic                          clr,
    alu_instr_controller_if.master        bus
);

    localparam int WW = $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_T6   = 3'd7
    } state_t;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic z_in;
        logic z_low_out;
        logic z_high_out;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic hi_in;
        logic lo_in;
    } strobe_t;

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == 5'b01110) || (op == 5'b01111);
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return ((op >= 5'b00011) && (op <= 5'b01011)) || is_muldiv(op);
    endfunction

    state_t        state_q, state_d;
    strobe_t       strb_q, strb_d;
    logic [15:0]   rin_q, rin_d;
    logic [15:0]   rout_q, rout_d;
    logic          rb_stage_q, rb_stage_d;
    logic [4:0]    opcode_q, opcode_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          unused_ir_s;

    assign unused_ir_s = ^bus.ir[14:0];

    // Next state and next-cycle strobes. Outputs are registered, so each branch
    // produces the strobe set for the state it is about to enter.
    always_comb begin
        state_d    = state_q;
        strb_d     = '0;
        rin_d      = 16'h0000;
        rout_d     = 16'h0000;
        rb_stage_d = 1'b0;
        opcode_d   = opcode_q;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        fault_d    = fault_q;
        wait_d     = wait_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d       = S_T0;
                    fault_d       = 1'b0;
                    strb_d.pc_out = 1'b1;
                    strb_d.mar_in = 1'b1;
                    strb_d.inc_pc = 1'b1;
                    strb_d.z_in   = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_T0: begin
                state_d          = S_T1;
                wait_d           = '0;
                strb_d.z_low_out = 1'b1;
                strb_d.pc_in     = 1'b1;
                strb_d.read      = 1'b1;
                strb_d.mdr_in    = 1'b1;
            end
            S_T1: begin
                if (bus.mem_ready) begin
                    state_d        = S_T2;
                    strb_d.mdr_out = 1'b1;
                    strb_d.ir_in   = 1'b1;
                end else if (wait_q == WW'(MEM_WAIT_MAX - 1)) begin
                    state_d = S_IDLE;
                    fault_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    wait_d        = wait_q + WW'(1);
                    strb_d.read   = 1'b1;
                    strb_d.mdr_in = 1'b1;
                end
            end
            S_T2: begin
                state_d     = S_T3;
                strb_d.y_in = 1'b1;
                rb_stage_d  = 1'b1;
            end
            S_T3: begin
                if (!is_legal(bus.ir[31:27])) begin
                    state_d = S_IDLE;
                    fault_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d     = S_T4;
                    strb_d.z_in = 1'b1;
                    rout_d      = onehot16(bus.ir[18:15]);
                    opcode_d    = bus.ir[31:27];
                end
            end
            S_T4: begin
                state_d          = S_T5;
                strb_d.z_low_out = 1'b1;
                if (is_muldiv(opcode_q)) begin
                    strb_d.lo_in = 1'b1;
                end else begin
                    rin_d  = onehot16(bus.ir[26:23]);
                    done_d = 1'b1;
                end
            end
            S_T5: begin
                if (is_muldiv(opcode_q)) begin
                    state_d           = S_T6;
                    strb_d.z_high_out = 1'b1;
                    strb_d.hi_in      = 1'b1;
                    done_d            = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_T6: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, strobe and status registers; clr aborts with no write-back.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            strb_q     <= '0;
            rin_q      <= 16'h0000;
            rout_q     <= 16'h0000;
            rb_stage_q <= 1'b0;
            opcode_q   <= 5'b00000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            strb_q     <= strb_d;
            rin_q      <= rin_d;
            rout_q     <= rout_d;
            rb_stage_q <= rb_stage_d;
            opcode_q   <= opcode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            wait_q     <= wait_d;
        end
    end

    // IR is only loaded on the T2->T3 edge, so the Rb select in T3 is decoded
    // from the live IR and gated by a registered stage flag.
    assign bus.Rout     = rout_q | (rb_stage_q ? onehot16(bus.ir[22:19]) : 16'h0000);
    assign bus.Rin      = rin_q;
    assign bus.PCout    = strb_q.pc_out;
    assign bus.MARin    = strb_q.mar_in;
    assign bus.incPC    = strb_q.inc_pc;
    assign bus.Zin      = strb_q.z_in;
    assign bus.ZLowOut  = strb_q.z_low_out;
    assign bus.ZHighOut = strb_q.z_high_out;
    assign bus.PCin     = strb_q.pc_in;
    assign bus.Read     = strb_q.read;
    assign bus.MDRin    = strb_q.mdr_in;
    assign bus.MDRout   = strb_q.mdr_out;
    assign bus.IRin     = strb_q.ir_in;
    assign bus.Yin      = strb_q.y_in;
    assign bus.HIin     = strb_q.hi_in;
    assign bus.LOin     = strb_q.lo_in;
    assign bus.opcode   = opcode_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.fault    = fault_q;

endmodule

// File: tb/tb_alu_instr_controller.sv
// Scoreboard bench: each instruction pushes its expected per-cycle output frames,
// and a negedge monitor pops and compares one frame per cycle.
module tb_alu_instr_controller;

    localparam int MEM_WAIT_MAX = 15;

    typedef struct packed {
        logic PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, Read, MDRin,
              MDRout, IRin, Yin, HIin, LOin;
        logic [15:0] Rin;
        logic [15:0] Rout;
        logic [4:0]  opcode;
        logic        busy, done, fault;
    } frame_t;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    alu_instr_controller_if bus();

    alu_instr_controller #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    frame_t act_s;
    assign act_s = {bus.PCout, bus.MARin, bus.incPC, bus.Zin, bus.ZLowOut, bus.ZHighOut,
                    bus.PCin, bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin,
                    bus.HIin, bus.LOin, bus.Rin, bus.Rout, bus.opcode,
                    bus.busy, bus.done, bus.fault};

    frame_t     exp_q[$];
    string      tag_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [4:0] exp_opcode;
    int         lim;
    int         npushed;

    task automatic check(input string tag, input frame_t e);
        checks++;
        if (act_s !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act_s, e);
        end
    endtask

    task automatic push(input string tag, input frame_t f);
        if (lim == 0 || npushed < lim) begin
            exp_q.push_back(f);
            tag_q.push_back(tag);
            npushed++;
        end
    endtask

    function automatic frame_t base();
        frame_t f = '0;
        f.opcode = exp_opcode;
        f.busy   = 1'b1;
        return f;
    endfunction

    // Expected frames from T0 through two trailing idle cycles.
    task automatic build(input string tag, input logic [31:0] ir, input int w);
        logic [4:0] op    = ir[31:27];
        logic [3:0] ra    = ir[26:23];
        logic [3:0] rb    = ir[22:19];
        logic [3:0] rc    = ir[18:15];
        bit         md    = (op == 5'd14) || (op == 5'd15);
        bit         legal = md || (op >= 5'd3 && op <= 5'd11);
        bit         tmo   = (w >= MEM_WAIT_MAX);
        int         nt1   = tmo ? MEM_WAIT_MAX : w + 1;
        bit         flt   = 1'b0;
        frame_t     f;
        f = base(); f.PCout = 1'b1; f.MARin = 1'b1; f.incPC = 1'b1; f.Zin = 1'b1;
        push({tag, " T0"}, f);
        for (int i = 0; i < nt1; i++) begin
            f = base(); f.Read = 1'b1; f.MDRin = 1'b1;
            if (i == 0) begin f.ZLowOut = 1'b1; f.PCin = 1'b1; end
            push({tag, " T1"}, f);
        end
        if (tmo) begin
            flt = 1'b1;
        end else begin
            f = base(); f.MDRout = 1'b1; f.IRin = 1'b1;
            push({tag, " T2"}, f);
            f = base(); f.Yin = 1'b1; f.Rout = 16'd1 << rb;
            push({tag, " T3"}, f);
            if (!legal) begin
                flt = 1'b1;
            end else begin
                exp_opcode = op;
                f = base(); f.Zin = 1'b1; f.Rout = 16'd1 << rc;
                push({tag, " T4"}, f);
                f = base(); f.ZLowOut = 1'b1;
                if (md) f.LOin = 1'b1;
                else begin f.Rin = 16'd1 << ra; f.done = 1'b1; end
                push({tag, " T5"}, f);
                if (md) begin
                    f = base(); f.ZHighOut = 1'b1; f.HIin = 1'b1; f.done = 1'b1;
                    push({tag, " T6"}, f);
                end
            end
        end
        f = '0; f.opcode = exp_opcode; f.fault = flt;
        push({tag, " idle1"}, f);
        push({tag, " idle2"}, f);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL %s drain: %0d frames left, required 0", tag, exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    // w = T1 wait cycles (>= MEM_WAIT_MAX never answers); poke pulses run in T2; rst4 pulls clr in T4.
    task automatic run_instr(input string tag, input logic [31:0] ir, input int w,
                             input bit poke, input bit rst4);
        frame_t z = '0;
        @(posedge clk); #1;
        bus.ir        = ir;
        bus.run       = 1'b1;
        bus.mem_ready = (w == 0);
        @(posedge clk); #1;
        bus.run = 1'b0;
        npushed = 0;
        lim     = rst4 ? 5 : 0;
        build(tag, ir, w);
        lim = 0;
        if (w > 0 && w < MEM_WAIT_MAX) begin
            repeat (w + 1) @(posedge clk);
            #1 bus.mem_ready = 1'b1;
        end
        if (poke) begin
            repeat (2) @(posedge clk);
            #1 bus.run = 1'b1;
            @(posedge clk);
            #1 bus.run = 1'b0;
        end
        if (rst4) begin
            repeat (4) @(posedge clk);
            #7 clr = 1'b0;
            #1 check({tag, " clr async"}, z);
            exp_opcode = 5'd0;
            push({tag, " clr held"}, z);
            @(negedge clk);
            #1 clr = 1'b1;
        end
        wait_drain(tag);
        bus.mem_ready = 1'b1;
    endtask

    // Monitor: one expected frame per cycle while the scoreboard holds any.
    always @(negedge clk) begin : monitor
        frame_t e;
        string  t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frame_t z = '0;
        clr           = 1'b0;
        bus.run       = 1'b0;
        bus.ir        = 32'h0000_0000;
        bus.mem_ready = 1'b1;
        exp_opcode    = 5'd0;
        lim           = 0;
        npushed       = 0;
        push("reset", z);
        @(negedge clk);
        #1 clr = 1'b1;

        run_instr("shra",     32'h389A_8000, 0, 1'b0, 1'b0);
        run_instr("memwait",  {5'd3, 4'd7, 4'd2, 4'd2, 15'd0}, 3, 1'b0, 1'b0);
        run_instr("timeout",  {5'd4, 4'd1, 4'd2, 4'd3, 15'd0}, MEM_WAIT_MAX, 1'b0, 1'b0);
        run_instr("illegal",  32'hF800_0000, 0, 1'b0, 1'b0);
        run_instr("mul",      32'h7123_0000, 0, 1'b0, 1'b0);
        run_instr("illegal2", {5'd12, 4'd2, 4'd3, 4'd4, 15'd0}, 0, 1'b0, 1'b0);
        run_instr("and_r0",   {5'd5, 4'd0, 4'd0, 4'd15, 15'd0}, 1, 1'b0, 1'b0);
        run_instr("div_r0",   {5'd15, 4'd0, 4'd9, 4'd9, 15'd0}, 0, 1'b0, 1'b0);
        run_instr("run_busy", {5'd6, 4'd3, 4'd4, 4'd5, 15'd0}, 0, 1'b1, 1'b0);
        run_instr("clr_t4",   {5'd11, 4'd8, 4'd1, 4'd2, 15'd0}, 0, 1'b0, 1'b1);
        run_instr("post_clr", {5'd9, 4'd15, 4'd14, 4'd13, 15'd0}, 2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_instr_controller.md
Name: alu_instr_controller

Overview:
- Control-sequencer FSM that drives the datapath control strobes for one register-format ALU instruction per `run` pulse: fetch (T0–T2), operand staging (T3–T4) and write-back (T5, plus T6 for mul/div).
- Replaces hand-driven strobe sequences in datapath benches; its outputs connect 1:1 to the datapath control inputs.
- Register-select outputs are one-hot, one bit per register, matching the per-register `RNin`/`RNout` datapath inputs.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles T1 waits for `mem_ready` before aborting with `fault`.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset; asynchronous, active-low.
- run  in  1  start one instruction; sampled only in IDLE.
- ir  in  32  IR contents; the controller reads it from T3 onward.
- mem_ready  in  1  memory data valid while Read is asserted.
- PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes.
- Rin  out  16  one-hot register write-enable; bit N drives RNin.
- Rout  out  16  one-hot register bus-drive; bit N drives RNout.
- opcode  out  5  ALU operation select.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the final write-back cycle.
- fault  out  1  sticky error flag; cleared on the next accepted `run`.

Behaviour:
- Registered Moore outputs. All strobes, `Rin`, `Rout`, `busy`, `done` and `fault` are 0 in reset. `opcode` resets to 5'b00000.
- Field decode:
  - opcode = ir[31:27]
  - Ra (destination) = ir[26:23]
  - Rb = ir[22:19]
  - Rc = ir[18:15]
- Supported opcodes (5'b): 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shra, 01000 shr, 01001 shl, 01010 ror, 01011 rol, 01110 mul, 01111 div.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- Per-state strobes (each held exactly one cycle unless noted):
  - IDLE: all strobes 0. run=1 → T0, and `fault` clears.
  - T0: PCout, MARin, incPC, Zin → T1.
  - T1: ZLowOut, PCin, Read, MDRin.
    - ZLowOut and PCin are asserted on the first T1 cycle only.
    - Read and MDRin stay asserted until mem_ready=1, then → T2.
    - A wait counter starts at 0 on T1 entry. If mem_ready is still 0 after MEM_WAIT_MAX cycles: fault=1, → IDLE.
  - T2: MDRout, IRin → T3.
  - T3: Rout[Rb], Yin.
    - Decode check: an unsupported opcode sets fault=1 and goes → IDLE with no register write.
    - Otherwise → T4.
  - T4: Rout[Rc], Zin; `opcode` output = decoded opcode → T5.
  - T5:
    - Non-mul/div: ZLowOut, Rin[Ra], done → IDLE.
    - mul/div: ZLowOut, LOin → T6.
  - T6 (mul/div only): ZHighOut, HIin, done → IDLE.
- `opcode` output holds its value from T4 until the next T4.
- Latency: with mem_ready=1 during T1, a non-mul/div instruction takes 6 cycles from the first T0 cycle to done, inclusive; mul/div takes 7. Each T1 wait cycle adds one.
- Bus exclusivity: never more than one bus driver (any Rout bit, PCout, ZLowOut, ZHighOut, MDRout) in the same cycle. At most one Rin bit high.
- Destination R0 (Ra=0) is legal; Rin[0] is asserted.
- Operands: Rb=Rc is legal. Ra equal to Rb or Rc is legal, since the write occurs after operands are staged.
- `run` while busy is ignored, with no queuing.
- `clr` low in any state: immediate return to IDLE with all outputs at reset values. The aborted instruction has no partial write-back.

Test Plan:
- shra R1,R3,R5: ir=32'h389A8000, mem_ready tied high, R3=32'hFFFFFFE0, R5=2, one run pulse → states T0..T5 on consecutive cycles; opcode=5'b00111 in T4; Rin=16'h0002 with ZLowOut in T5; done on cycle 6; R1=32'hFFFFFFF8.
- Memory wait: mem_ready held low for 3 cycles in T1 → Read/MDRin high for exactly 4 cycles; done on cycle 9; PCin high for only 1 cycle.
- Timeout: mem_ready held low with MEM_WAIT_MAX=15 → fault=1 after 15 T1 cycles; return to IDLE; Rin stays 0 throughout.
- Illegal opcode: ir=32'hF8000000 (opcode 11111) → fault=1 in the cycle after T3; no Zin in T4, no Rin; the next run with a valid ir clears fault.
- mul R2,R4,R6: ir=32'h71230000 → LOin with ZLowOut in T5; HIin with ZHighOut in T6; done on cycle 7; Rin=0 throughout.
- Reset and run-while-busy: clr asserted low mid-T4 → all outputs 0 within the same cycle; busy=0. A run pulse during T2 of a normal instruction → ignored; exactly one done is produced.
